// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game engine: directions, FSM states,
// colours, grid geometry and the reset position of the head.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MOVE  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DEAD  = 2'd3
  } state_t;

  localparam logic [11:0] COL_HEAD    = 12'h0F0;
  localparam logic [11:0] COL_BODY    = 12'h0A0;
  localparam logic [11:0] COL_APPLE   = 12'hF00;
  localparam logic [11:0] COL_BG      = 12'h000;
  localparam logic [11:0] COL_BG_DEAD = 12'h400;

  localparam int GRID_W = 80;
  localparam int GRID_H = 60;

  localparam logic [6:0] HEAD_X0 = 7'd40;
  localparam logic [5:0] HEAD_Y0 = 6'd30;

  // Opposite directions differ only in bit 0 with this encoding.
  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return (a ^ b) == 2'b01;
  endfunction

endpackage

// File: rtl/snake_pixel_mux.sv
// Per-pixel hit test of the current cell against head, body and apple, with a
// registered colour output (one cycle behind the pixel counters).
module snake_pixel_mux
  import snake_pkg::*;
#(
  parameter int SEG_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           x_count,
  input  logic [9:0]           y_count,
  input  logic                 video_on,
  input  logic [SEG_MAX*7-1:0] seg_x,
  input  logic [SEG_MAX*6-1:0] seg_y,
  input  logic [4:0]           length,
  input  logic [6:0]           apple_x,
  input  logic [5:0]           apple_y,
  input  logic                 game_over,
  output logic [11:0]          rgb
);

  logic [6:0]  col;
  logic [5:0]  row;
  logic        head_hit;
  logic        body_hit;
  logic        apple_hit;
  logic [11:0] colour;
  logic        unused_bits;

  assign col         = x_count[9:3];
  assign row         = y_count[8:3];
  assign unused_bits = ^{x_count[2:0], y_count[9], y_count[2:0]};

  always_comb begin
    head_hit  = (seg_x[6:0] == col) && (seg_y[5:0] == row);
    apple_hit = (apple_x == col) && (apple_y == row);
    body_hit  = 1'b0;
    // Segments at or beyond the current length hold stale data and are skipped.
    for (int i = 1; i < SEG_MAX; i++) begin
      if ((5'(i) < length) && (seg_x[i*7 +: 7] == col) && (seg_y[i*6 +: 6] == row))
        body_hit = 1'b1;
    end
    if (!video_on)      colour = 12'h000;
    else if (head_hit)  colour = COL_HEAD;
    else if (body_hit)  colour = COL_BODY;
    else if (apple_hit) colour = COL_APPLE;
    else if (game_over) colour = COL_BG_DEAD;
    else                colour = COL_BG;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rgb <= 12'h000;
    else     rgb <= colour;
  end

endmodule

// File: rtl/snake_engine.sv
// Snake game core: frame-tick paced movement, serial self-collision check,
// apple growth and segment storage; rendering is delegated to snake_pixel_mux.
module snake_engine
  import snake_pkg::*;
#(
  parameter int SEG_MAX     = 16,
  parameter int TICK_FRAMES = 6
) (
  input  logic        VGA_clk,
  input  logic        reset,
  input  logic [9:0]  xCount,
  input  logic [9:0]  yCount,
  input  logic        video_on,
  input  logic [1:0]  dir_in,
  input  logic        dir_valid,
  input  logic [6:0]  apple_x,
  input  logic [5:0]  apple_y,
  output logic [11:0] rgb,
  output logic        apple_eaten,
  output logic        game_over,
  output logic [4:0]  length
);

  localparam int FW = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
  localparam int IW = (SEG_MAX > 1) ? $clog2(SEG_MAX) : 1;

  logic [6:0]           seg_x [SEG_MAX];
  logic [5:0]           seg_y [SEG_MAX];
  logic [SEG_MAX*7-1:0] seg_x_flat;
  logic [SEG_MAX*6-1:0] seg_y_flat;

  state_t        state;
  dir_t          cur_dir;
  dir_t          pend_dir;
  logic [FW-1:0] frame_cnt;
  logic [IW-1:0] chk_idx;

  logic              frame_tick;
  logic              step;
  logic signed [7:0] nx, ny;
  logic              wall;
  logic              self_hit;
  logic              on_apple;

  assign frame_tick = (xCount == 10'd0) && (yCount == 10'd480);
  assign step       = frame_tick && (frame_cnt == FW'(TICK_FRAMES - 1));

  // Signed 8-bit advance so stepping off column/row 0 goes negative instead of wrapping.
  always_comb begin
    nx = $signed({1'b0, seg_x[0]});
    ny = $signed({2'b00, seg_y[0]});
    case (pend_dir)
      DIR_UP:   ny = ny - 8'sd1;
      DIR_DOWN: ny = ny + 8'sd1;
      DIR_LEFT: nx = nx - 8'sd1;
      default:  nx = nx + 8'sd1;
    endcase
  end

  assign wall = (nx < 8'sd0) || (nx > $signed(8'(GRID_W - 1))) ||
                (ny < 8'sd0) || (ny > $signed(8'(GRID_H - 1)));
  assign self_hit = (5'(chk_idx) < length) &&
                    (seg_x[chk_idx] == seg_x[0]) && (seg_y[chk_idx] == seg_y[0]);
  assign on_apple = (seg_x[0] == apple_x) && (seg_y[0] == apple_y);

  always_comb begin
    seg_x_flat = '0;
    seg_y_flat = '0;
    for (int i = 0; i < SEG_MAX; i++) begin
      seg_x_flat[i*7 +: 7] = seg_x[i];
      seg_y_flat[i*6 +: 6] = seg_y[i];
    end
  end

  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      length      <= 5'd3;
      cur_dir     <= DIR_RIGHT;
      pend_dir    <= DIR_RIGHT;
      frame_cnt   <= '0;
      chk_idx     <= IW'(1);
      apple_eaten <= 1'b0;
      game_over   <= 1'b0;
      for (int i = 0; i < SEG_MAX; i++) begin
        seg_x[i] <= 7'd0;
        seg_y[i] <= 6'd0;
      end
      seg_x[0] <= HEAD_X0;
      seg_y[0] <= HEAD_Y0;
      seg_x[1] <= HEAD_X0 - 7'd1;
      seg_y[1] <= HEAD_Y0;
      seg_x[2] <= HEAD_X0 - 7'd2;
      seg_y[2] <= HEAD_Y0;
    end else begin
      apple_eaten <= 1'b0;
      if (frame_tick)
        frame_cnt <= (frame_cnt == FW'(TICK_FRAMES - 1)) ? '0 : frame_cnt + 1'b1;
      if (dir_valid && !is_reverse(dir_t'(dir_in), cur_dir))
        pend_dir <= dir_t'(dir_in);

      case (state)
        ST_RUN: begin
          if (step) state <= ST_MOVE;
        end
        ST_MOVE: begin
          for (int i = 1; i < SEG_MAX; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= nx[6:0];
          seg_y[0] <= ny[5:0];
          cur_dir  <= pend_dir;
          chk_idx  <= IW'(1);
          if (wall) begin
            game_over <= 1'b1;
            state     <= ST_DEAD;
          end else begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (self_hit) begin
            game_over <= 1'b1;
            state     <= ST_DEAD;
          end else if (chk_idx == IW'(SEG_MAX - 1)) begin
            state <= ST_RUN;
            // The shift already copied the old tail one slot further, so growth is just length+1.
            if (on_apple) begin
              apple_eaten <= 1'b1;
              if (length < 5'(SEG_MAX)) length <= length + 5'd1;
            end
          end else begin
            chk_idx <= chk_idx + 1'b1;
          end
        end
        default: state <= ST_DEAD;
      endcase
    end
  end

  snake_pixel_mux #(.SEG_MAX(SEG_MAX)) u_pixel_mux (
    .clk       (VGA_clk),
    .rst       (reset),
    .x_count   (xCount),
    .y_count   (yCount),
    .video_on  (video_on),
    .seg_x     (seg_x_flat),
    .seg_y     (seg_y_flat),
    .length    (length),
    .apple_x   (apple_x),
    .apple_y   (apple_y),
    .game_over (game_over),
    .rgb       (rgb)
  );

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: expected pixel colours and apple pulses are
// queued at issue time and consumed by an independent monitor.
module tb_snake_engine;
  import snake_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  x_count, y_count;
  logic        video_on;
  logic [1:0]  dir_in;
  logic        dir_valid;
  logic [6:0]  apple_x;
  logic [5:0]  apple_y;
  logic [11:0] rgb;
  logic        apple_eaten, game_over;
  logic [4:0]  length;

  int errors = 0;
  int checks = 0;

  logic        probe = 1'b0;
  logic        probe_d = 1'b0;
  logic        apple_prev = 1'b0;
  logic [11:0] exp_q[$];
  string       name_q[$];
  int          apple_q[$];

  always #20 clk = ~clk;

  snake_engine #(.SEG_MAX(16), .TICK_FRAMES(6)) dut (
    .VGA_clk     (clk),
    .reset       (reset),
    .xCount      (x_count),
    .yCount      (y_count),
    .video_on    (video_on),
    .dir_in      (dir_in),
    .dir_valid   (dir_valid),
    .apple_x     (apple_x),
    .apple_y     (apple_y),
    .rgb         (rgb),
    .apple_eaten (apple_eaten),
    .game_over   (game_over),
    .length      (length)
  );

  always @(posedge clk) probe_d <= probe;

  // Monitor: rgb of a probed pixel is due one cycle after it was presented.
  always @(negedge clk) begin
    if (probe_d) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pixel_underflow: got rgb %h with nothing expected", rgb);
      end else begin
        logic [11:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (rgb !== e) begin
          errors++;
          $display("FAIL %s: got rgb %h expected %h", n, rgb, e);
        end
      end
    end
    if (apple_eaten === 1'b1) begin
      checks++;
      if (apple_prev) begin
        errors++;
        $display("FAIL apple_pulse_width: apple_eaten high on consecutive cycles");
      end else if (apple_q.size() == 0) begin
        errors++;
        $display("FAIL apple_unexpected: got apple_eaten=1 expected 0");
      end else begin
        void'(apple_q.pop_front());
      end
    end
    apple_prev = (apple_eaten === 1'b1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic park();
    x_count  = 10'd1;
    y_count  = 10'd481;
    video_on = 1'b0;
  endtask

  task automatic pix(input int c, input int r, input logic vo, input logic [11:0] e, input string nm);
    @(posedge clk); #1;
    x_count  = 10'(c * 8 + 3);
    y_count  = 10'(r * 8 + 5);
    video_on = vo;
    probe    = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk); #1;
    probe = 1'b0;
    park();
  endtask

  task automatic tick();
    @(posedge clk); #1;
    x_count = 10'd0;
    y_count = 10'd480;
    @(posedge clk); #1;
    park();
  endtask

  task automatic step();
    repeat (6) tick();
    repeat (24) @(posedge clk);
    #1;
  endtask

  task automatic set_dir(input logic [1:0] d);
    @(posedge clk); #1;
    dir_in    = d;
    dir_valid = 1'b1;
    @(posedge clk); #1;
    dir_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    park();
    dir_in    = 2'd0;
    dir_valid = 1'b0;
    apple_x   = 7'd70;
    apple_y   = 6'd5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rgb", 32'(rgb), 32'h000);
    check("rst_apple_eaten", 32'(apple_eaten), 0);
    check("rst_game_over", 32'(game_over), 0);
    check("rst_length", 32'(length), 3);
    check("rst_state", 32'(dut.state), 32'(ST_RUN));
    reset = 1'b0;

    // Initial picture
    pix(40, 30, 1'b1, 12'h0F0, "init_head");
    pix(39, 30, 1'b1, 12'h0A0, "init_body1");
    pix(38, 30, 1'b1, 12'h0A0, "init_body2");
    pix(37, 30, 1'b1, 12'h000, "init_bg_left");
    pix(41, 30, 1'b1, 12'h000, "init_bg_right");
    pix(0, 0, 1'b1, 12'h000, "init_stale_seg");
    pix(70, 5, 1'b1, 12'hF00, "init_apple");
    pix(40, 30, 1'b0, 12'h000, "blank_head");
    pix(79, 59, 1'b1, 12'h000, "init_corner");

    // Idle step
    step();
    check("idle_length", 32'(length), 3);
    pix(41, 30, 1'b1, 12'h0F0, "idle_head");
    pix(39, 30, 1'b1, 12'h0A0, "idle_tail");
    pix(38, 30, 1'b1, 12'h000, "idle_old_tail");

    // Reversal ignored, then a turn up
    set_dir(2'(DIR_LEFT));
    step();
    pix(42, 30, 1'b1, 12'h0F0, "rev_ignored_head");
    set_dir(2'(DIR_UP));
    step();
    pix(42, 29, 1'b1, 12'h0F0, "up_head");
    pix(42, 30, 1'b1, 12'h0A0, "up_body1");
    pix(41, 30, 1'b1, 12'h0A0, "up_body2");
    pix(43, 30, 1'b1, 12'h000, "up_bg");

    // Apple hit
    do_reset();
    apple_x = 7'd41;
    apple_y = 6'd30;
    apple_q.push_back(1);
    step();
    check("apple_length", 32'(length), 4);
    check("apple_pulse_seen", 32'(apple_q.size()), 0);
    apple_x = 7'd70;
    apple_y = 6'd5;
    pix(41, 30, 1'b1, 12'h0F0, "apple_head");
    pix(38, 30, 1'b1, 12'h0A0, "apple_new_tail");
    pix(37, 30, 1'b1, 12'h000, "apple_bg");

    // Wall collision at column 80
    do_reset();
    for (int k = 0; k < 39; k++) step();
    check("wall_pre_game_over", 32'(game_over), 0);
    step();
    check("wall_game_over", 32'(game_over), 1);
    check("wall_state", 32'(dut.state), 32'(ST_DEAD));
    pix(0, 0, 1'b1, 12'h400, "dead_bg");
    pix(79, 30, 1'b1, 12'h0A0, "dead_body1");
    step();
    pix(79, 30, 1'b1, 12'h0A0, "frozen_body1");
    pix(78, 30, 1'b1, 12'h0A0, "frozen_body2");
    pix(77, 30, 1'b1, 12'h400, "frozen_bg");
    check("frozen_length", 32'(length), 3);
    check("frozen_game_over", 32'(game_over), 1);

    // Self collision: grow to 5, then down, left, up into the body
    do_reset();
    apple_x = 7'd41;
    apple_y = 6'd30;
    apple_q.push_back(1);
    step();
    apple_x = 7'd42;
    apple_q.push_back(1);
    step();
    apple_x = 7'd70;
    apple_y = 6'd5;
    check("self_length", 32'(length), 5);
    set_dir(2'(DIR_DOWN));
    step();
    set_dir(2'(DIR_LEFT));
    step();
    check("self_pre_game_over", 32'(game_over), 0);
    set_dir(2'(DIR_UP));
    step();
    check("self_game_over", 32'(game_over), 1);
    check("self_state", 32'(dut.state), 32'(ST_DEAD));
    check("self_length_kept", 32'(length), 5);

    // Reset in the middle of CHECK
    do_reset();
    apple_x = 7'd41;
    apple_y = 6'd30;
    apple_q.push_back(1);
    step();
    apple_x = 7'd70;
    apple_y = 6'd5;
    repeat (5) tick();
    @(posedge clk); #1;
    x_count = 10'd0;
    y_count = 10'd480;
    @(posedge clk); #1;
    x_count  = 10'(42 * 8 + 3);
    y_count  = 10'(30 * 8 + 5);
    video_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mid_state", 32'(dut.state), 32'(ST_CHECK));
    check("mid_length", 32'(length), 4);
    check("mid_rgb", 32'(rgb), 32'h0F0);
    #5;
    reset = 1'b1;
    #1;
    check("async_state", 32'(dut.state), 32'(ST_RUN));
    check("async_length", 32'(length), 3);
    check("async_rgb", 32'(rgb), 32'h000);
    check("async_game_over", 32'(game_over), 0);
    check("async_apple_eaten", 32'(apple_eaten), 0);
    park();
    @(posedge clk); #1;
    reset = 1'b0;
    pix(40, 30, 1'b1, 12'h0F0, "post_rst_head");
    pix(42, 30, 1'b1, 12'h000, "post_rst_old_head");
    pix(38, 30, 1'b1, 12'h0A0, "post_rst_tail");

    repeat (4) @(posedge clk);
    #1;
    check("pix_queue_drained", 32'(exp_q.size()), 0);
    check("apple_queue_drained", 32'(apple_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
